// File: rtl/ntt_pkg.sv
// ntt_pkg: shared constants, types and address helpers for the
// Kyber NTT sequencer.
package ntt_pkg;

    localparam int N          = 256;
    localparam int LOG_N      = 8;
    localparam int NUM_LAYERS = 7;
    localparam int COEFF_W    = 12;
    localparam int ADDR_W     = 8;
    localparam int ZIDX_W     = 7;
    localparam int LAYER_W    = 3;
    localparam int BFLY_W     = 7;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        FINISH
    } ntt_state_t;

    typedef struct packed {
        logic              en;
        logic              we;
        logic [ADDR_W-1:0] addr;
    } bram_req_t;

    // Butterfly span of layer l: 128 >> l.
    function automatic logic [ADDR_W-1:0] bf_len(
        input logic [LAYER_W-1:0] l
    );
        return 8'd128 >> l;
    endfunction

    // Lower coefficient index j of butterfly b in layer l.
    function automatic logic [ADDR_W-1:0] bf_addr_j(
        input logic [LAYER_W-1:0] l,
        input logic [BFLY_W-1:0]  b
    );
        logic [LAYER_W-1:0] s;
        logic [ADDR_W-1:0]  bx;
        logic [ADDR_W-1:0]  grp;
        s   = 3'd7 - l;
        bx  = {1'b0, b};
        grp = (bx >> s) << (s + 3'd1);
        return grp | (bx & (bf_len(l) - 8'd1));
    endfunction

    // Forward (Cooley-Tukey) twiddle index: 2^l + group.
    function automatic logic [ZIDX_W-1:0] bf_zeta_fwd(
        input logic [LAYER_W-1:0] l,
        input logic [BFLY_W-1:0]  b
    );
        logic [ADDR_W-1:0] z;
        z = (8'd1 << l) + ({1'b0, b} >> (3'd7 - l));
        return z[ZIDX_W-1:0];
    endfunction

    // Inverse (Gentleman-Sande) twiddle index: 2^(l+1) - 1 - group.
    function automatic logic [ZIDX_W-1:0] bf_zeta_inv(
        input logic [LAYER_W-1:0] l,
        input logic [BFLY_W-1:0]  b
    );
        logic [ADDR_W-1:0] z;
        z = (8'd1 << (l + 3'd1)) - 8'd1
          - ({1'b0, b} >> (3'd7 - l));
        return z[ZIDX_W-1:0];
    endfunction

endpackage

// File: rtl/ntt_wb_pipe.sv
// ntt_wb_pipe: carries each read's address pair until its write-back
// slot and flags when the last in-flight butterfly is being written.
module ntt_wb_pipe
    import ntt_pkg::*;
#(
    parameter int DEPTH = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_valid,
    input  logic [ADDR_W-1:0] i_addr_a,
    input  logic [ADDR_W-1:0] i_addr_b,
    output logic              o_in_valid,
    output logic              o_wb_valid,
    output logic [ADDR_W-1:0] o_wb_addr_a,
    output logic [ADDR_W-1:0] o_wb_addr_b,
    output logic              o_drain_done
);

    localparam logic [DEPTH-1:0] LAST_ONLY = DEPTH'(1) << (DEPTH - 1);

    logic [DEPTH-1:0]  r_valid;
    logic [ADDR_W-1:0] r_addr_a [DEPTH];
    logic [ADDR_W-1:0] r_addr_b [DEPTH];

    // Shift valid and address pair one stage per cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_addr_a[i] <= '0;
                r_addr_b[i] <= '0;
            end
        end else begin
            r_valid[0]  <= i_valid;
            r_addr_a[0] <= i_addr_a;
            r_addr_b[0] <= i_addr_b;
            for (int i = 1; i < DEPTH; i++) begin
                r_valid[i]  <= r_valid[i-1];
                r_addr_a[i] <= r_addr_a[i-1];
                r_addr_b[i] <= r_addr_b[i-1];
            end
        end
    end

    assign o_in_valid   = r_valid[0];
    assign o_wb_valid   = r_valid[DEPTH-1];
    assign o_wb_addr_a  = r_addr_a[DEPTH-1];
    assign o_wb_addr_b  = r_addr_b[DEPTH-1];
    assign o_drain_done = (r_valid == LAST_ONLY);

endmodule

// File: rtl/ntt_ctrl.sv
// ntt_ctrl: 7-layer in-place Kyber NTT sequencer driving a dual-port BRAM.
// Define NTT_CTRL_INTT_EN to add inv/bf_inv for inverse (GS) runs.
module ntt_ctrl
    import ntt_pkg::*;
#(
    parameter int BF_LAT = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
`ifdef NTT_CTRL_INTT_EN
    input  logic              inv,
    output logic              bf_inv,
`endif
    output logic              busy,
    output logic              done,
    output logic              en_a,
    output logic              we_a,
    output logic [ADDR_W-1:0] addr_a,
    output logic              en_b,
    output logic              we_b,
    output logic [ADDR_W-1:0] addr_b,
    output logic              bf_in_valid,
    output logic [ZIDX_W-1:0] zeta_idx
);

    localparam logic [LAYER_W-1:0] L_FWD0 = '0;
    localparam logic [LAYER_W-1:0] L_FWDN = LAYER_W'(NUM_LAYERS - 1);
    localparam logic [BFLY_W-1:0]  B_LAST = BFLY_W'(N / 2 - 1);

    // Odd reads / even writes only hold for an even latency.
    if (BF_LAT < 0 || BF_LAT > 8 || (BF_LAT % 2) != 0) begin : g_bad_lat
        $error("ntt_ctrl: BF_LAT must be even and in 0..8");
    end

    ntt_state_t         r_state, w_state_nxt;
    logic [LAYER_W-1:0] r_layer, w_layer_nxt;
    logic [BFLY_W-1:0]  r_b, w_b_nxt;
    logic               r_phase, w_phase_nxt;
    logic [ZIDX_W-1:0]  r_zeta;
    logic [ADDR_W-1:0]  r_hold_a, r_hold_b;

    logic               w_inv_run, w_inv_start;
    logic               w_rd, w_last_layer;
    logic [LAYER_W-1:0] w_first_layer, w_step_layer;
    logic [ADDR_W-1:0]  w_addr_a, w_addr_b;
    logic [ZIDX_W-1:0]  w_zeta;
    logic               w_in_valid, w_wb_valid, w_drain_done;
    logic [ADDR_W-1:0]  w_wb_addr_a, w_wb_addr_b;
    bram_req_t          w_req_a, w_req_b;

`ifdef NTT_CTRL_INTT_EN
    logic r_inv;

    // Latch the transform direction when a run is accepted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_inv <= 1'b0;
        else if (r_state == IDLE && start)
            r_inv <= inv;
    end

    assign bf_inv      = r_inv;
    assign w_inv_run   = r_inv;
    assign w_inv_start = inv;
`else
    assign w_inv_run   = 1'b0;
    assign w_inv_start = 1'b0;
`endif

    assign w_rd          = (r_state == RUN) && !r_phase;
    assign w_first_layer = w_inv_start ? L_FWDN : L_FWD0;
    assign w_last_layer  = (r_layer == (w_inv_run ? L_FWD0 : L_FWDN));
    assign w_step_layer  = w_inv_run ? r_layer - 3'd1 : r_layer + 3'd1;
    assign w_addr_a      = bf_addr_j(r_layer, r_b);
    assign w_addr_b      = w_addr_a + bf_len(r_layer);
    assign w_zeta        = w_inv_run ? bf_zeta_inv(r_layer, r_b)
                                     : bf_zeta_fwd(r_layer, r_b);

    ntt_wb_pipe #(
        .DEPTH (BF_LAT + 1)
    ) u_wb_pipe (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_valid      (w_rd),
        .i_addr_a     (w_addr_a),
        .i_addr_b     (w_addr_b),
        .o_in_valid   (w_in_valid),
        .o_wb_valid   (w_wb_valid),
        .o_wb_addr_a  (w_wb_addr_a),
        .o_wb_addr_b  (w_wb_addr_b),
        .o_drain_done (w_drain_done)
    );

    // State, layer, butterfly and read-phase registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_layer <= '0;
            r_b     <= '0;
            r_phase <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_layer <= w_layer_nxt;
            r_b     <= w_b_nxt;
            r_phase <= w_phase_nxt;
        end
    end

    // Sequencing: one read every other cycle, drain between layers.
    always_comb begin
        w_state_nxt = r_state;
        w_layer_nxt = r_layer;
        w_b_nxt     = r_b;
        w_phase_nxt = r_phase;
        unique case (r_state)
            IDLE: begin
                if (start) begin
                    w_state_nxt = RUN;
                    w_layer_nxt = w_first_layer;
                    w_b_nxt     = '0;
                    w_phase_nxt = 1'b0;
                end
            end
            RUN: begin
                w_phase_nxt = ~r_phase;
                if (r_phase) begin
                    w_b_nxt = r_b + 7'd1;
                end else if (r_b == B_LAST) begin
                    w_state_nxt = DRAIN;
                    w_phase_nxt = 1'b0;
                end
            end
            DRAIN: begin
                if (w_drain_done) begin
                    if (w_last_layer) begin
                        w_state_nxt = FINISH;
                    end else begin
                        w_state_nxt = RUN;
                        w_layer_nxt = w_step_layer;
                        w_b_nxt     = '0;
                        w_phase_nxt = 1'b0;
                    end
                end
            end
            FINISH: w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Port requests: write-back wins its even slot, reads use odd slots.
    always_comb begin
        w_req_a.en   = w_rd | w_wb_valid;
        w_req_a.we   = w_wb_valid;
        w_req_a.addr = r_hold_a;
        w_req_b.en   = w_rd | w_wb_valid;
        w_req_b.we   = w_wb_valid;
        w_req_b.addr = r_hold_b;
        if (w_wb_valid) begin
            w_req_a.addr = w_wb_addr_a;
            w_req_b.addr = w_wb_addr_b;
        end else if (w_rd) begin
            w_req_a.addr = w_addr_a;
            w_req_b.addr = w_addr_b;
        end
    end

    // Keep the last driven addresses and align zeta with operand data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_zeta   <= '0;
            r_hold_a <= '0;
            r_hold_b <= '0;
        end else begin
            if (w_rd)
                r_zeta <= w_zeta;
            if (w_req_a.en)
                r_hold_a <= w_req_a.addr;
            if (w_req_b.en)
                r_hold_b <= w_req_b.addr;
        end
    end

    assign busy        = (r_state == RUN) || (r_state == DRAIN);
    assign done        = (r_state == FINISH);
    assign en_a        = w_req_a.en;
    assign we_a        = w_req_a.we;
    assign addr_a      = w_req_a.addr;
    assign en_b        = w_req_b.en;
    assign we_b        = w_req_b.we;
    assign addr_b      = w_req_b.addr;
    assign bf_in_valid = w_in_valid;
    assign zeta_idx    = r_zeta;

endmodule

// File: tb/tb_ntt_ctrl.sv
// tb_ntt_ctrl: directed bench for ntt_ctrl (BF_LAT=2 timing instance
// plus a BF_LAT=4 instance wired to a BRAM and golden butterfly model).
`timescale 1ns/1ps
module tb_ntt_ctrl;
    import ntt_pkg::*;

    localparam int Q = 3329;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic start4 = 1'b0;
    logic mdl_init = 1'b0;

    logic busy, done, en_a, we_a, en_b, we_b, bf_in_valid;
    logic [7:0] addr_a, addr_b;
    logic [6:0] zeta_idx;
    logic busy4, done4, en_a4, we_a4, en_b4, we_b4, bf_in_valid4;
    logic [7:0] addr_a4, addr_b4;
    logic [6:0] zeta_idx4;
`ifdef NTT_CTRL_INTT_EN
    logic inv = 1'b0;
    logic bf_inv, bf_inv4;
`endif

    int cyc = 0;
    int n_cmp = 0;
    int n_bad = 0;
    bit mon_en = 1'b0;
    int busy_bad = 0;
    int done_cnt = 0;

    logic [COEFF_W-1:0] mem [N];
    logic [COEFF_W-1:0] dout_a4, dout_b4;
    int bf_a [4];
    int bf_b [4];
    int ref_poly [N];

    always #5 clk = ~clk;

    ntt_ctrl #(.BF_LAT(2)) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start),
`ifdef NTT_CTRL_INTT_EN
        .inv(inv), .bf_inv(bf_inv),
`endif
        .busy(busy), .done(done),
        .en_a(en_a), .we_a(we_a), .addr_a(addr_a),
        .en_b(en_b), .we_b(we_b), .addr_b(addr_b),
        .bf_in_valid(bf_in_valid), .zeta_idx(zeta_idx)
    );

    ntt_ctrl #(.BF_LAT(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .start(start4),
`ifdef NTT_CTRL_INTT_EN
        .inv(1'b0), .bf_inv(bf_inv4),
`endif
        .busy(busy4), .done(done4),
        .en_a(en_a4), .we_a(we_a4), .addr_a(addr_a4),
        .en_b(en_b4), .we_b(we_b4), .addr_b(addr_b4),
        .bf_in_valid(bf_in_valid4), .zeta_idx(zeta_idx4)
    );

    function automatic int zeta_of(int k);
        int e = 0;
        int z = 1;
        for (int i = 0; i < 7; i++)
            e = e | (((k >> i) & 1) << (6 - i));
        for (int i = 0; i < e; i++)
            z = (z * 17) % Q;
        return z;
    endfunction

    function automatic int init_coef(int i);
        return (i * 37 + 11) % Q;
    endfunction

    // BRAM model: true dual port, one-cycle read latency.
    always @(posedge clk) begin
        if (mdl_init) begin
            for (int i = 0; i < N; i++)
                mem[i] <= COEFF_W'(init_coef(i));
        end else begin
            if (en_a4) begin
                if (we_a4) mem[addr_a4] <= COEFF_W'(bf_a[3]);
                else dout_a4 <= mem[addr_a4];
            end
            if (en_b4) begin
                if (we_b4) mem[addr_b4] <= COEFF_W'(bf_b[3]);
                else dout_b4 <= mem[addr_b4];
            end
        end
    end

    // Golden CT butterfly with a 4-cycle latency.
    always @(posedge clk) begin
        int t;
        t = (zeta_of(int'(zeta_idx4)) * int'(dout_b4)) % Q;
        bf_a[0] <= bf_in_valid4 ? (int'(dout_a4) + t) % Q : 0;
        bf_b[0] <= bf_in_valid4 ? (int'(dout_a4) - t + Q) % Q : 0;
        for (int i = 1; i < 4; i++) begin
            bf_a[i] <= bf_a[i-1];
            bf_b[i] <= bf_b[i-1];
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(negedge clk);
        cyc++;
        if (mon_en) begin
            if (busy !== (cyc <= 1806)) busy_bad++;
            if (done === 1'b1) done_cnt++;
        end
    endtask

    task automatic goto(input int n);
        while (cyc < n) tick();
    endtask

    task automatic launch(input bit sel);
        @(negedge clk);
        if (sel) start4 = 1'b1;
        else start = 1'b1;
        cyc = 0;
        tick();
        start = 1'b0;
        start4 = 1'b0;
    endtask

    task automatic test_reset();
        logic [29:0] act;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        act = {busy, done, en_a, we_a, en_b, we_b,
               bf_in_valid, addr_a, addr_b, zeta_idx};
        n_cmp++;
        if (act !== 30'd0) begin
            n_bad++;
            $display("FAIL reset_outputs: got %h want 0", act);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_first_bfly();
        logic [19:0] act;
        mon_en = 1'b1;
        busy_bad = 0;
        done_cnt = 0;
        launch(1'b0);
        act = {en_a, we_a, en_b, we_b, addr_a, addr_b};
        n_cmp++;
        if (act !== {4'b1010, 8'd0, 8'd128}) begin
            n_bad++;
            $display("FAIL c1_read: got %h want %h",
                     act, {4'b1010, 8'd0, 8'd128});
        end
        tick();
        n_cmp++;
        if ({bf_in_valid, zeta_idx, en_a} !== {1'b1, 7'd1, 1'b0}) begin
            n_bad++;
            $display("FAIL c2_bfin: got v=%b z=%0d en=%b want 1/1/0",
                     bf_in_valid, zeta_idx, en_a);
        end
        tick();
        act = {en_a, we_a, en_b, we_b, addr_a, addr_b};
        n_cmp++;
        if (act !== {4'b1010, 8'd1, 8'd129}) begin
            n_bad++;
            $display("FAIL c3_read1: got %h want %h",
                     act, {4'b1010, 8'd1, 8'd129});
        end
        tick();
        act = {en_a, we_a, en_b, we_b, addr_a, addr_b};
        n_cmp++;
        if (act !== {4'b1111, 8'd0, 8'd128}) begin
            n_bad++;
            $display("FAIL c4_write: got %h want %h",
                     act, {4'b1111, 8'd0, 8'd128});
        end
    endtask

    task automatic test_layer_boundary();
        logic [19:0] act;
        goto(257);
        n_cmp++;
        if ({en_a, en_b} !== 2'b00) begin
            n_bad++;
            $display("FAIL c257_gap: got en=%b%b want 00", en_a, en_b);
        end
        goto(258);
        act = {en_a, we_a, en_b, we_b, addr_a, addr_b};
        n_cmp++;
        if (act !== {4'b1111, 8'd127, 8'd255}) begin
            n_bad++;
            $display("FAIL c258_lastwr: got %h want %h",
                     act, {4'b1111, 8'd127, 8'd255});
        end
        goto(259);
        act = {en_a, we_a, en_b, we_b, addr_a, addr_b};
        n_cmp++;
        if (act !== {4'b1010, 8'd0, 8'd64}) begin
            n_bad++;
            $display("FAIL c259_l1rd: got %h want %h",
                     act, {4'b1010, 8'd0, 8'd64});
        end
        goto(387);
        act = {en_a, we_a, en_b, we_b, addr_a, addr_b};
        n_cmp++;
        if (act !== {4'b1010, 8'd128, 8'd192}) begin
            n_bad++;
            $display("FAIL l1_b64_addr: got %h want %h",
                     act, {4'b1010, 8'd128, 8'd192});
        end
        goto(388);
        n_cmp++;
        if ({bf_in_valid, zeta_idx} !== {1'b1, 7'd3}) begin
            n_bad++;
            $display("FAIL l1_b64_zeta: got v=%b z=%0d want 1/3",
                     bf_in_valid, zeta_idx);
        end
    endtask

    task automatic test_last_layer_done();
        logic [19:0] act;
        goto(1803);
        act = {en_a, we_a, en_b, we_b, addr_a, addr_b};
        n_cmp++;
        if (act !== {4'b1010, 8'd253, 8'd255}) begin
            n_bad++;
            $display("FAIL l6_b127_addr: got %h want %h",
                     act, {4'b1010, 8'd253, 8'd255});
        end
        goto(1804);
        n_cmp++;
        if ({bf_in_valid, zeta_idx} !== {1'b1, 7'd127}) begin
            n_bad++;
            $display("FAIL l6_b127_zeta: got v=%b z=%0d want 1/127",
                     bf_in_valid, zeta_idx);
        end
        goto(1806);
        act = {en_a, we_a, en_b, we_b, addr_a, addr_b};
        n_cmp++;
        if (act !== {4'b1111, 8'd253, 8'd255}) begin
            n_bad++;
            $display("FAIL l6_lastwr: got %h want %h",
                     act, {4'b1111, 8'd253, 8'd255});
        end
        goto(1807);
        n_cmp++;
        if ({done, busy, en_a} !== 3'b100) begin
            n_bad++;
            $display("FAIL c1807_done: got d/b/en=%b%b%b want 100",
                     done, busy, en_a);
        end
        goto(1808);
        mon_en = 1'b0;
        n_cmp++;
        if (busy_bad != 0) begin
            n_bad++;
            $display("FAIL busy_window: got %0d bad cycles want 0",
                     busy_bad);
        end
        n_cmp++;
        if (done_cnt != 1) begin
            n_bad++;
            $display("FAIL done_once: got %0d pulses want 1", done_cnt);
        end
    endtask

    task automatic test_model_ntt();
        int z;
        int t;
        int k;
        int nerr;
        int first;
        @(negedge clk);
        mdl_init = 1'b1;
        @(negedge clk);
        mdl_init = 1'b0;
        for (int i = 0; i < N; i++) ref_poly[i] = init_coef(i);
        k = 1;
        for (int len = 128; len >= 2; len = len / 2) begin
            for (int st = 0; st < N; st = st + 2 * len) begin
                z = zeta_of(k);
                k++;
                for (int j = st; j < st + len; j++) begin
                    t = (z * ref_poly[j + len]) % Q;
                    ref_poly[j + len] = (ref_poly[j] - t + Q) % Q;
                    ref_poly[j] = (ref_poly[j] + t) % Q;
                end
            end
        end
        launch(1'b1);
        while (done4 !== 1'b1 && cyc < 2500) tick();
        n_cmp++;
        if (cyc != 1821) begin
            n_bad++;
            $display("FAIL lat4_done_cycle: got %0d want 1821", cyc);
        end
        repeat (2) tick();
        nerr = 0;
        first = -1;
        for (int i = 0; i < N; i++) begin
            if (int'(mem[i]) != ref_poly[i]) begin
                nerr++;
                if (first < 0) first = i;
            end
        end
        n_cmp++;
        if (nerr != 0) begin
            n_bad++;
            $display("FAIL ntt_result: %0d coeffs differ, first idx %0d got %0d want %0d",
                     nerr, first, mem[first], ref_poly[first]);
        end
    endtask

    task automatic test_restart_and_reset();
        logic [29:0] act;
        int seen;
        launch(1'b0);
        goto(100);
        start = 1'b1;
        tick();
        start = 1'b0;
        goto(387);
        n_cmp++;
        if ({en_a, we_a, addr_a, addr_b} !== {2'b10, 8'd128, 8'd192}) begin
            n_bad++;
            $display("FAIL restart_ignored: got en=%b we=%b a=%0d b=%0d",
                     en_a, we_a, addr_a, addr_b);
        end
        goto(500);
        #2 rst_n = 1'b0;
        #1;
        act = {busy, done, en_a, we_a, en_b, we_b,
               bf_in_valid, addr_a, addr_b, zeta_idx};
        n_cmp++;
        if (act !== 30'd0) begin
            n_bad++;
            $display("FAIL midrun_reset: got %h want 0", act);
        end
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        repeat (5) begin
            tick();
            if (done === 1'b1 || busy === 1'b1) seen++;
        end
        n_cmp++;
        if (seen != 0) begin
            n_bad++;
            $display("FAIL post_reset_idle: got %0d busy/done cycles want 0",
                     seen);
        end
        launch(1'b0);
        while (done !== 1'b1 && cyc < 2500) tick();
        n_cmp++;
        if (cyc != 1807) begin
            n_bad++;
            $display("FAIL rerun_done_cycle: got %0d want 1807", cyc);
        end
    endtask

    task automatic test_back_to_back();
        tick();
        @(negedge clk);
        start = 1'b1;
        cyc = 0;
        tick();
        while (done !== 1'b1 && cyc < 2500) tick();
        n_cmp++;
        if (cyc != 1807) begin
            n_bad++;
            $display("FAIL b2b_done_cycle: got %0d want 1807", cyc);
        end
        tick();
        n_cmp++;
        if ({busy, en_a} !== 2'b00) begin
            n_bad++;
            $display("FAIL b2b_idle_gap: got busy=%b en=%b want 00",
                     busy, en_a);
        end
        tick();
        n_cmp++;
        if ({busy, en_a, we_a, addr_a, addr_b} !==
            {3'b110, 8'd0, 8'd128}) begin
            n_bad++;
            $display("FAIL b2b_retrigger: got busy=%b en=%b we=%b a=%0d b=%0d",
                     busy, en_a, we_a, addr_a, addr_b);
        end
        start = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

`ifdef NTT_CTRL_INTT_EN
    task automatic test_inverse();
        inv = 1'b1;
        launch(1'b0);
        inv = 1'b0;
        n_cmp++;
        if ({en_a, we_a, addr_a, addr_b} !== {2'b10, 8'd0, 8'd2}) begin
            n_bad++;
            $display("FAIL inv_first_read: got en=%b we=%b a=%0d b=%0d",
                     en_a, we_a, addr_a, addr_b);
        end
        tick();
        n_cmp++;
        if ({bf_in_valid, zeta_idx, bf_inv} !== {1'b1, 7'd127, 1'b1}) begin
            n_bad++;
            $display("FAIL inv_first_zeta: got v=%b z=%0d inv=%b want 1/127/1",
                     bf_in_valid, zeta_idx, bf_inv);
        end
        goto(1549);
        n_cmp++;
        if ({en_a, we_a, addr_a, addr_b} !== {2'b10, 8'd0, 8'd128}) begin
            n_bad++;
            $display("FAIL inv_last_layer: got en=%b we=%b a=%0d b=%0d",
                     en_a, we_a, addr_a, addr_b);
        end
        goto(1550);
        n_cmp++;
        if ({bf_in_valid, zeta_idx} !== {1'b1, 7'd1}) begin
            n_bad++;
            $display("FAIL inv_last_zeta: got v=%b z=%0d want 1/1",
                     bf_in_valid, zeta_idx);
        end
        while (done !== 1'b1 && cyc < 2500) tick();
        n_cmp++;
        if (cyc != 1807) begin
            n_bad++;
            $display("FAIL inv_done_cycle: got %0d want 1807", cyc);
        end
        tick();
    endtask
`endif

    initial begin
        test_reset();
        test_first_bfly();
        test_layer_boundary();
        test_last_layer_done();
        test_model_ntt();
        test_restart_and_reset();
        test_back_to_back();
`ifdef NTT_CTRL_INTT_EN
        test_inverse();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
